// File: rtl/poker_pkg.sv
// Shared widths, card counts and round states
// for the poker round controller and its evaluator.
package poker_pkg;
  localparam int RANK_W = 4;
  localparam int SUIT_W = 2;
  localparam int PUB_CARDS = 5;
  localparam int HOLE_PER_PLAYER = 2;
  localparam logic [RANK_W-1:0] RANK_MIN = 4'd2;
  localparam logic [RANK_W-1:0] RANK_MAX = 4'd14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_HOLE,
    ST_LOAD_PUB,
    ST_EVAL,
    ST_OUT
  } state_t;
endpackage

// File: rtl/poker_round_ctrl_ip.sv
// Combinational hold'em evaluator: best 5-of-7 per player,
// returns a mask of every player holding the top hand.
module poker_round_ctrl_ip
  import poker_pkg::*;
#(
  parameter int IP_WIDTH = 9
) (
  input  logic [IP_WIDTH*HOLE_PER_PLAYER*RANK_W-1:0] hole_num,
  input  logic [IP_WIDTH*HOLE_PER_PLAYER*SUIT_W-1:0] hole_suit,
  input  logic [PUB_CARDS*RANK_W-1:0]                pub_num,
  input  logic [PUB_CARDS*SUIT_W-1:0]                pub_suit,
  output logic [IP_WIDTH-1:0]                        winner
);
  localparam int H7 = HOLE_PER_PLAYER + PUB_CARDS;

  function automatic logic [19:0] top_ranks(
    input logic [15:0] m,
    input int          n
  );
    logic [19:0] o;
    int k;
    o = '0;
    k = 0;
    for (int r = 14; r >= 2; r--) begin
      if (m[r] && k < n) begin
        o[19-4*k -: 4] = 4'(r);
        k++;
      end
    end
    return o;
  endfunction

  // Score = {category, five tie-break ranks}; larger wins.
  function automatic logic [23:0] score7(
    input logic [H7*4-1:0] num,
    input logic [H7*2-1:0] suit
  );
    logic [2:0] cnt [16];
    logic [2:0] sc [4];
    logic [15:0] rm, fm;
    logic [1:0] fs;
    logic fl;
    logic [3:0] st, sf, quad, trip, p1, p2, r4, cat;
    logic [19:0] tb;
    for (int r = 0; r < 16; r++) cnt[r] = '0;
    for (int s = 0; s < 4; s++) sc[s] = '0;
    for (int i = 0; i < H7; i++) begin
      cnt[num[4*i +: 4]] = cnt[num[4*i +: 4]] + 3'd1;
      sc[suit[2*i +: 2]] = sc[suit[2*i +: 2]] + 3'd1;
    end
    fl = 1'b0;
    fs = '0;
    for (int s = 0; s < 4; s++) begin
      if (sc[s] >= 3'd5) begin
        fl = 1'b1;
        fs = 2'(s);
      end
    end
    rm = '0;
    fm = '0;
    for (int i = 0; i < H7; i++) begin
      rm[num[4*i +: 4]] = 1'b1;
      if (fl && suit[2*i +: 2] == fs) fm[num[4*i +: 4]] = 1'b1;
    end
    // ace also plays low for the wheel
    rm[1] = rm[14];
    fm[1] = fm[14];
    st = '0;
    sf = '0;
    for (int r = 5; r <= 14; r++) begin
      if (&rm[r -: 5]) st = 4'(r);
      if (&fm[r -: 5]) sf = 4'(r);
    end
    quad = '0;
    trip = '0;
    p1 = '0;
    p2 = '0;
    for (int r = 14; r >= 2; r--) begin
      r4 = 4'(r);
      if (cnt[r] == 3'd4) begin
        if (quad == '0) quad = r4;
      end else if (cnt[r] == 3'd3 && trip == '0) begin
        trip = r4;
      end else if (cnt[r] >= 3'd2) begin
        if (p1 == '0) p1 = r4;
        else if (p2 == '0) p2 = r4;
      end
    end
    if (sf != '0) begin
      cat = 4'd8;
      tb = {sf, 16'd0};
    end else if (quad != '0) begin
      cat = 4'd7;
      tb = {quad, 16'd0}
         | (top_ranks(rm & ~(16'd1 << quad), 1) >> 4);
    end else if (trip != '0 && p1 != '0) begin
      cat = 4'd6;
      tb = {trip, p1, 12'd0};
    end else if (fl) begin
      cat = 4'd5;
      tb = top_ranks(fm, 5);
    end else if (st != '0) begin
      cat = 4'd4;
      tb = {st, 16'd0};
    end else if (trip != '0) begin
      cat = 4'd3;
      tb = {trip, 16'd0}
         | (top_ranks(rm & ~(16'd1 << trip), 2) >> 4);
    end else if (p2 != '0) begin
      cat = 4'd2;
      tb = {p1, p2, 12'd0}
         | (top_ranks(rm & ~(16'd1 << p1)
              & ~(16'd1 << p2), 1) >> 8);
    end else if (p1 != '0) begin
      cat = 4'd1;
      tb = {p1, 16'd0}
         | (top_ranks(rm & ~(16'd1 << p1), 3) >> 4);
    end else begin
      cat = 4'd0;
      tb = top_ranks(rm, 5);
    end
    return {cat, tb};
  endfunction

  logic [23:0] score [IP_WIDTH];
  logic [23:0] best;

  for (genvar p = 0; p < IP_WIDTH; p++) begin : g_pl
    assign score[p] = score7(
      {hole_num[8*p +: 8], pub_num},
      {hole_suit[4*p +: 4], pub_suit});
  end

  always_comb begin
    best = '0;
    winner = '0;
    for (int p = 0; p < IP_WIDTH; p++) begin
      if (score[p] > best) best = score[p];
    end
    for (int p = 0; p < IP_WIDTH; p++) begin
      winner[p] = (score[p] == best);
    end
  end
endmodule

// File: rtl/poker_round_ctrl.sv
// Collects one round of hole and public cards, runs the
// evaluator and strobes the winner mask for one cycle.
module poker_round_ctrl
  import poker_pkg::*;
#(
  parameter int IP_WIDTH = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [RANK_W-1:0]   card_num,
  input  logic [SUIT_W-1:0]   card_suit,
  output logic                in_ready,
  output logic                out_valid,
  output logic [IP_WIDTH-1:0] out_winner,
  output logic                out_err
);
  localparam int HOLE_N = HOLE_PER_PLAYER * IP_WIDTH;
  localparam logic [4:0] HOLE_LAST = 5'(HOLE_N - 1);
  localparam logic [4:0] PUB_LAST = 5'(PUB_CARDS - 1);

  state_t state;
  logic [4:0] cnt;
  logic err;
  logic accept, bad;
  logic [HOLE_N*RANK_W-1:0] hole_num;
  logic [HOLE_N*SUIT_W-1:0] hole_suit;
  logic [PUB_CARDS*RANK_W-1:0] pub_num;
  logic [PUB_CARDS*SUIT_W-1:0] pub_suit;
  logic [IP_WIDTH-1:0] ip_winner, win_q;

  assign in_ready = state inside {ST_IDLE, ST_LOAD_HOLE, ST_LOAD_PUB};
  assign accept = in_valid && in_ready;
  assign bad = card_num < RANK_MIN || card_num > RANK_MAX;
  assign out_valid = (state == ST_OUT);
  assign out_winner = out_valid ? win_q : '0;
  assign out_err = out_valid && err;

  // Card storage is fully rewritten every round, so no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      if (state == ST_LOAD_PUB) begin
        pub_num[RANK_W*int'(cnt) +: RANK_W] <= card_num;
        pub_suit[SUIT_W*int'(cnt) +: SUIT_W] <= card_suit;
      end else begin
        hole_num[RANK_W*int'(cnt) +: RANK_W] <= card_num;
        hole_suit[SUIT_W*int'(cnt) +: SUIT_W] <= card_suit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt <= '0;
      err <= 1'b0;
      win_q <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_LOAD_HOLE: begin
          if (accept) begin
            err <= err | bad;
            if (cnt == HOLE_LAST) begin
              cnt <= '0;
              state <= ST_LOAD_PUB;
            end else begin
              cnt <= cnt + 5'd1;
              state <= ST_LOAD_HOLE;
            end
          end
        end
        ST_LOAD_PUB: begin
          if (accept) begin
            err <= err | bad;
            cnt <= cnt + 5'd1;
            if (cnt == PUB_LAST) state <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          win_q <= err ? '0 : ip_winner;
          state <= ST_OUT;
        end
        ST_OUT: begin
          cnt <= '0;
          err <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  poker_round_ctrl_ip #(
    .IP_WIDTH(IP_WIDTH)
  ) u_ip (
    .hole_num (hole_num),
    .hole_suit(hole_suit),
    .pub_num  (pub_num),
    .pub_suit (pub_suit),
    .winner   (ip_winner)
  );
endmodule

// File: doc/poker_round_ctrl.md
POKER_ROUND_CTRL -- requirements
Module: poker_round_ctrl

Interface
REQ-001 Parameter: IP_WIDTH, default 9, number of players; SHALL be in the range 2..9.
REQ-002 Port: clk  input  1  single clock; all logic SHALL be rising-edge triggered.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: in_valid  input  1  a card is presented this cycle.
REQ-005 Port: card_num  input  4  card rank, legal values 2..14 (14 = ace).
REQ-006 Port: card_suit  input  2  card suit, any value is legal.
REQ-007 Port: in_ready  output  1  the block accepts a card this cycle.
REQ-008 Port: out_valid  output  1  one-cycle result strobe.
REQ-009 Port: out_winner  output  IP_WIDTH  winner mask; bit p set means player p wins or ties.
REQ-010 Port: out_err  output  1  the round contained an illegal rank.

Function
REQ-011 A card SHALL be accepted only on a cycle where in_valid and in_ready are both 1; in_valid while in_ready=0 SHALL be ignored.
REQ-012 A round SHALL be exactly 2*IP_WIDTH hole cards followed by 5 public cards, in arrival order; idle gaps (in_valid=0) between cards SHALL be allowed.
REQ-013 Packing of hole cards: hole card i (0-based) SHALL go to hole-num bits [4i+3:4i] and hole-suit bits [2i+1:2i]; player p therefore owns hole cards 2p and 2p+1.
REQ-014 Packing of public cards: public card j SHALL go to pub-num bits [4j+3:4j] and pub-suit bits [2j+1:2j].
REQ-015 The FSM SHALL have the states IDLE, LOAD_HOLE, LOAD_PUB, EVAL and OUT.
 - IDLE->LOAD_HOLE on the first accepted card.
 - LOAD_HOLE->LOAD_PUB after hole card 2*IP_WIDTH-1 is accepted.
 - LOAD_PUB->EVAL after public card 4 is accepted.
 - EVAL->OUT unconditionally.
 - OUT->IDLE unconditionally.
REQ-016 in_ready SHALL be 1 in IDLE, LOAD_HOLE and LOAD_PUB, and 0 in EVAL and OUT.
REQ-017 Card counter: 5 bits, cleared on entry to LOAD_PUB and on entry to IDLE; it SHALL never wrap within a round.
REQ-018 In EVAL the evaluator output SHALL be registered; in OUT, out_valid=1 for exactly one cycle with the registered mask.
REQ-019 Latency: out_valid SHALL rise exactly 2 cycles after the cycle in which the 5th public card is accepted.
REQ-020 A rank outside 2..14 SHALL set a sticky error flag for the round.
 - The card is still counted.
 - At OUT: out_err=1 and out_winner=0.
 - The flag clears on OUT->IDLE.
REQ-021 out_winner and out_err SHALL be 0 whenever out_valid=0.
REQ-022 A card presented during OUT SHALL be ignored, because in_ready=0; the next round starts at the earliest in IDLE, one cycle after out_valid.

Reset
REQ-023 On rst=1 at a clock edge the block SHALL enter IDLE with in_ready=1 and out_valid=0, out_winner=0, out_err=0, counter=0 and error flag=0.
REQ-024 Reset during LOAD_HOLE, LOAD_PUB, EVAL or OUT SHALL abort the round; no out_valid SHALL be produced for the aborted round.
REQ-025 Card storage registers need not be reset; every bit is rewritten before use.

Structure
REQ-026 Shared package poker_pkg SHALL hold the following items.
 - Rank width (4) and suit width (2).
 - Public card count (5) and hole cards per player (2).
 - Legal rank bounds (2, 14).
 - The state enum.
REQ-027 The evaluator SHALL be the existing combinational Poker IP, instantiated once with IP_WIDTH passed through; the controller SHALL add no other sub-module.
REQ-028 Storage: a shift or indexed register file of 2*IP_WIDTH + 5 cards, feeding the IP inputs directly.

Verification
REQ-029 IP_WIDTH=9; player 3 holds A-spade and K-spade, the board is Q, J and 10 of spades plus 2 and 3 of hearts, all others hold off-suit low cards -> out_winner=9'b000001000, out_err=0, with out_valid 2 cycles after the last card.
REQ-030 Board is A, K, Q, J, 10 of mixed suits and all hole cards are rank 2..5 -> out_winner=9'h1FF.
REQ-031 Same deal as REQ-029 with 3 idle cycles inserted after every card -> same mask; in_ready stays 1 throughout loading.
REQ-032 Hole card 7 has rank 1 -> out_err=1 and out_winner=0; the next round, with all ranks legal, gives out_err=0.
REQ-033 rst asserted after 10 hole cards, then a full legal round -> exactly one out_valid, matching a fresh-reset reference.
REQ-034 in_valid held high during EVAL and OUT with junk cards -> no effect on the mask, and the card counter stays unchanged.
